spi_afe_master: RTL and testbench

SPI master that drives the board's AFE link pins (`spi_clk_o`, `spi_mosi_o`, `spi_miso_i`, `spi_sel` latch, `sel0`, `sel1`) from single-word commands issued by the PCIe/DMA register side. Each command shifts 1–32 bits MSB-first in SPI mode 0 and pulses the `spi_sel` latch after the last bit. Each command returns a response pulse, with readback data when that path is compiled in. It sits directly downstream of the DMA/register space and directly upstream of the board's SPI pins.

---
 rtl/spi_afe_pkg.sv | 24 ++
 rtl/spi_afe_tick.sv | 33 +++
 rtl/spi_afe_master.sv | 146 ++++++++++++++
 tb/tb_spi_afe_master.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_afe_pkg.sv
// Shared types and widths for the AFE SPI master: state encoding, bus widths, length decode.
package spi_afe_pkg;

  localparam int SPI_LEN_W  = 5;
  localparam int SPI_DATA_W = 32;
  localparam int SPI_DIV_W  = 8;
  localparam int SPI_CNT_W  = SPI_LEN_W + 1;
  // Phase counter must cover the LATCH phase, which is twice the SCK half-period.
  localparam int PH_W       = SPI_DIV_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_H,
    S_SHIFT_L,
    S_LATCH,
    S_DONE
  } spi_state_e;

  function automatic logic [SPI_CNT_W-1:0] decode_len(input logic [SPI_LEN_W-1:0] len);
    return (len == '0) ? SPI_CNT_W'(SPI_DATA_W) : {1'b0, len};
  endfunction

endpackage

// File: rtl/spi_afe_tick.sv
// Phase timer: strobes tick_o on the last cycle of a phase of phase_len_i cycles.
// Restarts whenever the controlling FSM changes state; held cleared while idle.
module spi_afe_tick
  import spi_afe_pkg::*;
(
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            clear_i,
  input  logic            restart_i,
  input  logic [PH_W-1:0] phase_len_i,
  output logic            tick_o
);

  logic [PH_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + PH_W'(1);
    if (clear_i || restart_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == phase_len_i - PH_W'(1));

endmodule

// File: rtl/spi_afe_master.sv
// Single-word SPI mode-0 master for the AFE link; response CLK_DIV*(3+2*len)+1 cycles after accept.
// No command queueing (cmd_ready only in IDLE); readback capture compiled in by SPI_AFE_READBACK_EN.
module spi_afe_master
  import spi_afe_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SPI_DATA_W-1:0] cmd_wdata,
  input  logic [SPI_LEN_W-1:0]  cmd_len,
  input  logic [1:0]            cmd_dev,
  output logic                  rsp_valid,
  output logic [SPI_DATA_W-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  spi_clk_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i,
  output logic                  spi_sel,
  output logic                  sel0,
  output logic                  sel1
);

  localparam logic [PH_W-1:0] HALF_LEN  = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] LATCH_LEN = PH_W'(2 * CLK_DIV);

  spi_state_e            state_q, state_d;
  logic [SPI_DATA_W-1:0] tx_q, tx_d;
  logic [SPI_CNT_W-1:0]  len_q, len_d;
  logic [SPI_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]            dev_q, dev_d;
  logic                  sck_q, mosi_q, latch_q, rsp_valid_q;
  logic [1:0]            sel_q;
  logic                  tick;
  logic                  accept;

  assign accept    = (state_q == S_IDLE) && cmd_valid;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

  spi_afe_tick u_tick (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .clear_i     (state_q == S_IDLE),
    .restart_i   (state_d != state_q),
    .phase_len_i ((state_q == S_LATCH) ? LATCH_LEN : HALF_LEN),
    .tick_o      (tick)
  );

  // tx is left-aligned so the next MOSI bit is always the MSB.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    len_d     = len_q;
    dev_d     = dev_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = S_SETUP;
          len_d     = decode_len(cmd_len);
          tx_d      = cmd_wdata << (SPI_CNT_W'(SPI_DATA_W) - len_d);
          dev_d     = cmd_dev;
          bit_cnt_d = '0;
        end
      end
      S_SETUP:   if (tick) state_d = S_SHIFT_H;
      S_SHIFT_H: begin
        if (tick) begin
          state_d   = S_SHIFT_L;
          bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
          tx_d      = tx_q << 1;
        end
      end
      S_SHIFT_L: if (tick) state_d = (bit_cnt_q == len_q) ? S_LATCH : S_SHIFT_H;
      S_LATCH:   if (tick) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Pins are registered from next-state so they line up with the state they belong to.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      tx_q        <= '0;
      len_q       <= '0;
      bit_cnt_q   <= '0;
      dev_q       <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      latch_q     <= 1'b0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      len_q       <= len_d;
      bit_cnt_q   <= bit_cnt_d;
      dev_q       <= dev_d;
      sck_q       <= (state_d == S_SHIFT_H);
      mosi_q      <= (state_d inside {S_SETUP, S_SHIFT_H, S_SHIFT_L}) && tx_d[SPI_DATA_W-1];
      latch_q     <= (state_d == S_LATCH);
      sel_q       <= (state_d inside {S_SETUP, S_SHIFT_H, S_SHIFT_L, S_LATCH}) ? dev_d : 2'b00;
      rsp_valid_q <= (state_d == S_DONE);
    end
  end

`ifdef SPI_AFE_READBACK_EN
  logic [SPI_DATA_W-1:0] rx_q, rx_d, rdata_q;

  always_comb begin
    rx_d = rx_q;
    if (accept) begin
      rx_d = '0;
    end else if (state_q == S_SHIFT_H && tick) begin
      rx_d = {rx_q[SPI_DATA_W-2:0], spi_miso_i};
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_q    <= '0;
      rdata_q <= '0;
    end else begin
      rx_q <= rx_d;
      if (state_d == S_DONE) rdata_q <= rx_q;
    end
  end

  assign rsp_rdata = rdata_q;
`else
  logic unused_miso;
  assign unused_miso = spi_miso_i;
  assign rsp_rdata   = '0;
`endif

  assign rsp_valid  = rsp_valid_q;
  assign spi_clk_o  = sck_q;
  assign spi_mosi_o = mosi_q;
  assign spi_sel    = latch_q;
  assign {sel1, sel0} = sel_q;

endmodule

// File: tb/tb_spi_afe_master.sv
// Directed bench: two instances (CLK_DIV=2 and CLK_DIV=1) driven from a vector table plus hand sequences.
module tb_spi_afe_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] wd = '0;
  logic [4:0]  ln = '0;
  logic [1:0]  dv = '0;
  logic [1:0]  mmode = 2'd2;
  logic        use_b = 1'b0;

  always #5 clk = ~clk;

  logic a_valid, a_ready, a_rsp, a_busy, a_sck, a_mosi, a_miso, a_spisel, a_sel0, a_sel1;
  logic b_valid, b_ready, b_rsp, b_busy, b_sck, b_mosi, b_miso, b_spisel, b_sel0, b_sel1;
  logic [31:0] a_rdata, b_rdata;

  assign a_valid = cmd_valid & ~use_b;
  assign b_valid = cmd_valid & use_b;
  assign a_miso  = (mmode == 2'd0) ? a_mosi : (mmode == 2'd1);
  assign b_miso  = (mmode == 2'd0) ? b_mosi : (mmode == 2'd1);

  spi_afe_master #(.CLK_DIV(2)) u_dut_div2 (
    .sys_clk(clk), .sys_rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_wdata(wd), .cmd_len(ln), .cmd_dev(dv), .rsp_valid(a_rsp), .rsp_rdata(a_rdata),
    .busy(a_busy), .spi_clk_o(a_sck), .spi_mosi_o(a_mosi), .spi_miso_i(a_miso),
    .spi_sel(a_spisel), .sel0(a_sel0), .sel1(a_sel1)
  );

  spi_afe_master #(.CLK_DIV(1)) u_dut_div1 (
    .sys_clk(clk), .sys_rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_wdata(wd), .cmd_len(ln), .cmd_dev(dv), .rsp_valid(b_rsp), .rsp_rdata(b_rdata),
    .busy(b_busy), .spi_clk_o(b_sck), .spi_mosi_o(b_mosi), .spi_miso_i(b_miso),
    .spi_sel(b_spisel), .sel0(b_sel0), .sel1(b_sel1)
  );

  logic o_ready, o_rsp, o_busy, o_sck, o_mosi, o_spisel, o_sel0, o_sel1;
  logic [31:0] o_rdata;
  assign o_ready  = use_b ? b_ready  : a_ready;
  assign o_rsp    = use_b ? b_rsp    : a_rsp;
  assign o_busy   = use_b ? b_busy   : a_busy;
  assign o_sck    = use_b ? b_sck    : a_sck;
  assign o_mosi   = use_b ? b_mosi   : a_mosi;
  assign o_spisel = use_b ? b_spisel : a_spisel;
  assign o_sel0   = use_b ? b_sel0   : a_sel0;
  assign o_sel1   = use_b ? b_sel1   : a_sel1;
  assign o_rdata  = use_b ? b_rdata  : a_rdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] captured);
`ifdef SPI_AFE_READBACK_EN
    return captured;
`else
    return (captured & 32'h0);
`endif
  endfunction

  typedef struct {
    bit          ub;
    logic [31:0] w;
    logic [4:0]  l;
    logic [1:0]  d;
    logic [1:0]  m;
    int          lat;
    int          rises;
    logic [31:0] mcap;
    logic [31:0] rd;
    int          selhi;
  } vec_t;

  vec_t vecs[6];

  int          r_lat, r_rises, r_sel, r_pin, r_mosi;
  logic [31:0] r_mcap, r_rd;
  logic        r_busy;

  // Issues one command and records what the pins did until the response (or a 2000-cycle budget).
  task automatic run_cmd(input bit ub, input logic [31:0] w, input logic [4:0] l,
                         input logic [1:0] d, input logic [1:0] m);
    logic prev_sck, prev_mosi;
    @(negedge clk);
    use_b = ub; wd = w; ln = l; dv = d; mmode = m; cmd_valid = 1'b1;
    chk("ready_before_accept", {31'd0, o_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    r_lat = -1; r_rises = 0; r_sel = 0; r_pin = 0; r_mosi = 0; r_mcap = '0; r_rd = '0;
    r_busy = o_busy & ~o_ready;
    prev_sck = 1'b0; prev_mosi = o_mosi;
    for (int c = 1; c < 2000; c++) begin
      if (c > 1) @(negedge clk);
      if (o_sck && !prev_sck) begin
        r_rises++;
        r_mcap = {r_mcap[30:0], o_mosi};
      end
      if (o_sck && (o_mosi !== prev_mosi)) r_mosi++;
      if (o_spisel) r_sel++;
      if (o_rsp) begin
        if ({o_sel1, o_sel0} !== 2'b00) r_pin++;
        r_lat = c;
        r_rd  = o_rdata;
        break;
      end else if ({o_sel1, o_sel0} !== d) begin
        r_pin++;
      end
      prev_sck = o_sck; prev_mosi = o_mosi;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, cnt;
    logic [31:0] rd1, rd2;

    vecs[0] = '{1'b0, 32'h0000_00A5, 5'd8,  2'b01, 2'd0, 39,  8, 32'h0000_00A5, 32'h0000_00A5, 4};
    vecs[1] = '{1'b1, 32'h8000_0001, 5'd0,  2'b10, 2'd0, 68, 32, 32'h8000_0001, 32'h8000_0001, 2};
    vecs[2] = '{1'b0, 32'h0000_0012, 5'd5,  2'b11, 2'd1, 27,  5, 32'h0000_0012, 32'h0000_001F, 4};
    vecs[3] = '{1'b1, 32'hFFFF_FFFE, 5'd1,  2'b00, 2'd1,  6,  1, 32'h0000_0000, 32'h0000_0001, 2};
    vecs[4] = '{1'b0, 32'hDEAD_3C5A, 5'd16, 2'b10, 2'd2, 71, 16, 32'h0000_3C5A, 32'h0000_0000, 4};
    vecs[5] = '{1'b1, 32'h4000_0001, 5'd31, 2'b01, 2'd0, 66, 31, 32'h4000_0001, 32'h4000_0001, 2};

    // Reset values
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pins_div2", {24'd0, a_sck, a_mosi, a_spisel, a_sel0, a_sel1, a_rsp, a_busy, a_ready}, 32'h01);
    chk("rst_pins_div1", {24'd0, b_sck, b_mosi, b_spisel, b_sel0, b_sel1, b_rsp, b_busy, b_ready}, 32'h01);
    chk("rst_rdata", a_rdata | b_rdata, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i].ub, vecs[i].w, vecs[i].l, vecs[i].d, vecs[i].m);
      chk($sformatf("v%0d_rsp_cycle", i), r_lat, vecs[i].lat);
      chk($sformatf("v%0d_sck_rises", i), r_rises, vecs[i].rises);
      chk($sformatf("v%0d_mosi_bits", i), r_mcap, vecs[i].mcap);
      chk($sformatf("v%0d_rdata", i), r_rd, exp_rd(vecs[i].rd));
      chk($sformatf("v%0d_latch_cycles", i), r_sel, vecs[i].selhi);
      chk($sformatf("v%0d_dev_sel_errs", i), r_pin, 0);
      chk($sformatf("v%0d_mosi_while_sck_hi", i), r_mosi, 0);
      chk($sformatf("v%0d_busy", i), {31'd0, r_busy}, 32'd1);
    end

    // cmd_valid held high with changing data: second command only after the first response
    @(negedge clk);
    use_b = 1'b0; wd = 32'h3C; ln = 5'd8; dv = 2'b01; mmode = 2'd0; cmd_valid = 1'b1;
    first = -1; second = -1; rd1 = '0; rd2 = '0;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      if (c == 1) wd = 32'hC3;
      if (c == 20) chk("b2b_not_ready_mid", {31'd0, o_ready}, 32'd0);
      if (c == 40) chk("b2b_ready_after_rsp", {31'd0, o_ready}, 32'd1);
      if (o_rsp) begin
        if (first < 0) begin
          first = c; rd1 = o_rdata;
        end else begin
          second = c; rd2 = o_rdata; cmd_valid = 1'b0;
          break;
        end
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_first_rsp", first, 39);
    chk("b2b_second_rsp", second, 79);
    chk("b2b_first_rdata", rd1, exp_rd(32'h3C));
    chk("b2b_second_rdata", rd2, exp_rd(32'hC3));
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_rsp) cnt++;
    end
    chk("b2b_no_extra_rsp", cnt, 0);

    // Reset pulsed during SHIFT_H of bit 3
    @(negedge clk);
    use_b = 1'b0; wd = 32'hFF; ln = 5'd8; dv = 2'b11; mmode = 2'd1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("mr_in_shift_h", {30'd0, a_sck, a_busy}, 32'h3);
    rst = 1'b1;
    #1;
    chk("mr_pins_async", {24'd0, a_sck, a_mosi, a_spisel, a_sel0, a_sel1, a_rsp, a_busy, a_ready}, 32'h01);
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b0;
      if (a_rsp) cnt++;
    end
    chk("mr_no_rsp", cnt, 0);
    chk("mr_ready_after", {31'd0, a_ready}, 32'd1);
    run_cmd(1'b0, 32'h5A, 5'd8, 2'b10, 2'd0);
    chk("mr_next_rsp_cycle", r_lat, 39);
    chk("mr_next_mosi_bits", r_mcap, 32'h5A);
    chk("mr_next_rdata", r_rd, exp_rd(32'h5A));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
